// File: rtl/key_cmd_queue.sv
// key_cmd_queue: decodes key-release scancodes into 5-bit display commands
// and buffers them in a fall-through FIFO behind a valid/ready handshake.
module key_cmd_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    scancode,
    input  logic          flag,
    input  logic          cmd_ready,
    input  logic          ovf_clr,
    output logic [4:0]    cmd,
    output logic          cmd_valid,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [7:0]    drop_cnt
);

    localparam int unsigned CW       = 5;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [CW-1:0] mem_q [DEPTH];
    logic [CW-1:0] mem_d [DEPTH];

    logic          stg_vld_q, stg_vld_d;
    logic [CW-1:0] stg_cmd_q, stg_cmd_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          dec_hit;
    logic [CW-1:0] dec_cmd;
    logic          pop_c;
    logic          push_c;

    // Scancode to command translation; anything not listed is unmapped.
    always_comb begin
        dec_hit = 1'b1;
        dec_cmd = '0;
        case (scancode)
            8'h45: dec_cmd = 5'd0;
            8'h16: dec_cmd = 5'd1;
            8'h1E: dec_cmd = 5'd2;
            8'h26: dec_cmd = 5'd3;
            8'h25: dec_cmd = 5'd4;
            8'h2E: dec_cmd = 5'd5;
            8'h36: dec_cmd = 5'd6;
            8'h3D: dec_cmd = 5'd7;
            8'h3E: dec_cmd = 5'd8;
            8'h46: dec_cmd = 5'd9;
            8'h21: dec_cmd = 5'd10;
            8'h43: dec_cmd = 5'd11;
            8'h33: dec_cmd = 5'd12;
            8'h2A: dec_cmd = 5'd13;
            8'h2D: dec_cmd = 5'd16;
            8'h34: dec_cmd = 5'd17;
            8'h32: dec_cmd = 5'd18;
            8'h1C: dec_cmd = 5'd19;
            8'h3A: dec_cmd = 5'd20;
            default: dec_hit = 1'b0;
        endcase
    end

    // Handshake qualifiers; a push may use the slot freed by a same-cycle pop.
    always_comb begin
        pop_c  = (level_q != '0) && cmd_ready;
        push_c = stg_vld_q && ((level_q != LVL_FULL) || pop_c);
    end

    // Next-state for decode stage, FIFO storage, pointers and status.
    always_comb begin
        stg_vld_d  = flag && dec_hit;
        stg_cmd_d  = dec_cmd;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (flag && !dec_hit && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'(1);
        end

        if (push_c) begin
            mem_d[wr_ptr_q] = stg_cmd_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push_c, pop_c})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase

        // A fresh drop outranks a clear on the same edge.
        if (stg_vld_q && !push_c) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_vld_q  <= 1'b0;
            stg_cmd_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            stg_vld_q  <= stg_vld_d;
            stg_cmd_q  <= stg_cmd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage array is not reset; stale entries are unreachable after reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Fall-through head; forced to zero while empty so reset presents cmd=0.
    always_comb begin
        cmd_valid = (level_q != '0);
        cmd       = cmd_valid ? mem_q[rd_ptr_q] : '0;
        level     = level_q;
        overflow  = overflow_q;
        drop_cnt  = drop_cnt_q;
    end

endmodule

// File: tb/tb_key_cmd_queue.sv
// Scoreboard bench for key_cmd_queue: a queue-based reference model tracks
// accepted commands; a negedge monitor compares the DUT against it.
module tb_key_cmd_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    scancode;
    logic          flag;
    logic          cmd_ready;
    logic          ovf_clr;
    logic [4:0]    cmd;
    logic          cmd_valid;
    logic [AW:0]   level;
    logic          overflow;
    logic [7:0]    drop_cnt;

    int checks   = 0;
    int failures = 0;

    logic [7:0] codes [19] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                               8'h3D, 8'h3E, 8'h46, 8'h21, 8'h43, 8'h33, 8'h2A,
                               8'h2D, 8'h34, 8'h32, 8'h1C, 8'h3A};
    int         vals  [19] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13,
                               16, 17, 18, 19, 20};
    logic [7:0] fill_codes [9] = '{8'h2D, 8'h34, 8'h32, 8'h1C, 8'h3A,
                                   8'h21, 8'h43, 8'h33, 8'h2A};
    int         fill_vals  [8] = '{16, 17, 18, 19, 20, 10, 11, 12};

    // reference model state
    int mq[$];
    bit m_stg;
    int m_stg_cmd;
    bit m_ovf;
    int m_drop;

    key_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .scancode  (scancode),
        .flag      (flag),
        .cmd_ready (cmd_ready),
        .ovf_clr   (ovf_clr),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic int map_code(input logic [7:0] sc);
        for (int i = 0; i < 19; i++) begin
            if (codes[i] == sc) return vals[i];
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a key that decodes joins the queue one edge after it
    // is seen, unless the queue is full with nobody taking the head.
    initial begin
        bit pop, push;
        int code;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                m_stg = 0; m_stg_cmd = 0; m_ovf = 0; m_drop = 0;
            end else begin
                pop  = (mq.size() != 0) && cmd_ready;
                push = m_stg && ((mq.size() < DEPTH) || pop);
                if (m_stg && !push) m_ovf = 1;
                else if (ovf_clr)   m_ovf = 0;
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back(m_stg_cmd);
                code = map_code(scancode);
                m_stg     = flag && (code >= 0);
                m_stg_cmd = (code >= 0) ? code : 0;
                if (flag && code < 0 && m_drop < 255) m_drop++;
            end
        end
    end

    // Monitor: compare every DUT output against the model away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("cmd_valid", int'(cmd_valid), int'(mq.size() != 0));
                chk("level", int'(level), mq.size());
                chk("level_bound", int'(level <= DEPTH), 1);
                if (mq.size() != 0) chk("cmd_head", int'(cmd), mq[0]);
                chk("overflow", int'(overflow), int'(m_ovf));
                chk("drop_cnt", int'(drop_cnt), m_drop);
            end
        end
    end

    // Apply inputs at a negedge, return at the following negedge.
    task automatic cyc(input logic f, input logic [7:0] sc, input logic rdy, input logic clr);
        flag = f; scancode = sc; cmd_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill8();
        for (int i = 0; i < 8; i++) cyc(1'b1, fill_codes[i], 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        int last;
        reset = 1'b1; flag = 1'b0; scancode = 8'h00; cmd_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_level", int'(level), 0);
        reset = 1'b0;

        // single key latency
        cyc(1'b1, 8'h16, 1'b0, 1'b0);
        chk("single_early", int'(cmd_valid), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("single_valid", int'(cmd_valid), 1);
        chk("single_cmd", int'(cmd), 1);
        chk("single_level", int'(level), 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_pop_valid", int'(cmd_valid), 0);
        chk("single_pop_level", int'(level), 0);

        // mapping sweep
        for (int i = 0; i < 19; i++) begin
            cyc(1'b1, codes[i], 1'b0, 1'b0);
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            chk("sweep_cmd", int'(cmd), vals[i]);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b1, 8'hF0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("unmapped_level", int'(level), 0);
        chk("unmapped_drops", int'(drop_cnt), 2);

        // fill and overflow
        for (int i = 0; i < 9; i++) cyc(1'b1, fill_codes[i], 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("fill_level", int'(level), 8);
        chk("fill_overflow", int'(overflow), 1);
        for (int i = 0; i < 8; i++) begin
            chk("fill_drain", int'(cmd), fill_vals[i]);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("fill_empty", int'(level), 0);

        // overflow clear on a quiet cycle
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clear", int'(overflow), 0);

        // full with simultaneous push and pop
        fill8();
        chk("full_level", int'(level), 8);
        cyc(1'b1, 8'h45, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("full_pp_level", int'(level), 8);
        chk("full_pp_ovf", int'(overflow), 0);
        last = -1;
        for (int i = 0; i < 8; i++) begin
            last = int'(cmd);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("full_pp_last", last, 0);

        // overflow set and clear on the same edge
        fill8();
        cyc(1'b1, 8'h2D, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_set_wins", int'(overflow), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clear2", int'(overflow), 0);
        drain(8);

        // pointer wrap with random consumer
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, codes[$urandom_range(18, 0)], 1'($urandom_range(1, 0)), 1'b0);
            cyc(1'b0, 8'h00, 1'($urandom_range(1, 0)), 1'b0);
        end
        drain(12);
        chk("wrap_empty", int'(level), 0);

        // reset mid-operation
        for (int i = 0; i < 5; i++) cyc(1'b1, codes[i + 3], 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_rst_level", int'(level), 5);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", int'(cmd_valid), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_ovf", int'(overflow), 0);
        chk("arst_drop", int'(drop_cnt), 0);
        chk("arst_cmd", int'(cmd), 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, 8'h1E, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_cmd", int'(cmd), 2);
        chk("post_rst_level", int'(level), 1);
        drain(1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] sc;
            sc = ($urandom_range(3, 0) != 0) ? codes[$urandom_range(18, 0)] : 8'($urandom);
            cyc(1'($urandom_range(1, 0)), sc, 1'($urandom_range(2, 0) == 0),
                1'($urandom_range(15, 0) == 0));
        end
        drain(12);
        chk("final_empty", int'(level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
